bp_be_tlb_miss_arbiter: RTL and testbench

- Shares one page-table walker (bp_be_mock_ptw-compatible) between ITLB and DTLB miss ports.
- Accepts one miss at a time using round-robin priority, sequences the walk request, and routes the returned vtag/ptag fill to the TLB that missed.
- Sits between the bp_be_tlb miss_v_o/miss_vtag_o outputs, the PTW, and the TLB write ports (w_v_i/w_vtag_i/w_ptag_i).

---
 rtl/bp_be_pkg.sv | 21 ++
 rtl/bp_be_tlb_miss_rr_arb.sv | 28 ++
 rtl/bp_be_tlb_miss_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bp_be_tlb_miss_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared back-end types for the TLB miss arbiter: FSM states, miss source ids, safe clog2.
// Purely declarative; no latency or flow control of its own.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

package bp_be_pkg;

   typedef enum logic [1:0] {
      e_state_idle = 2'd0,
      e_state_req  = 2'd1,
      e_state_wait = 2'd2,
      e_state_fill = 2'd3
   } bp_be_tlb_miss_state_e;

   typedef enum logic {
      e_src_itlb = 1'b0,
      e_src_dtlb = 1'b1
   } bp_be_tlb_miss_src_e;

endpackage

// File: rtl/bp_be_tlb_miss_rr_arb.sv
// Two-input round-robin picker for ITLB/DTLB misses; combinational, zero latency.
// Grants only while en_i is high; the requester not granted last wins a tie.
module bp_be_tlb_miss_rr_arb
   import bp_be_pkg::*;
   (
      input  logic [1:0]          v_i,
      input  bp_be_tlb_miss_src_e last_grant_i,
      input  logic                en_i,
      output logic [1:0]          grant_o,
      output bp_be_tlb_miss_src_e grant_id_o
   );

   always_comb begin
      grant_o    = 2'b00;
      grant_id_o = e_src_itlb;
      if (en_i) begin
         if (v_i == 2'b11) begin
            grant_id_o = (last_grant_i == e_src_dtlb) ? e_src_itlb : e_src_dtlb;
         end else if (v_i[1]) begin
            grant_id_o = e_src_dtlb;
         end
         if (v_i != 2'b00) begin
            grant_o = (grant_id_o == e_src_dtlb) ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: rtl/bp_be_tlb_miss_arbiter.sv
// Shares one PTW between ITLB/DTLB misses: round-robin grant, walk request, fill routed to owner;
// min 5 cycles grant-to-fill with a 3-cycle PTW; one walk at a time. Walk watchdog: BP_BE_TLB_MISS_TIMEOUT_EN.
module bp_be_tlb_miss_arbiter
   import bp_be_pkg::*;
   #(
      parameter int vtag_width_p     = 27,
      parameter int ptag_width_p     = 28,
      parameter int timeout_cycles_p = 256
   )
   (
      input  logic                    clk,
      input  logic                    reset,

      input  logic                    itlb_miss_v_i,
      input  logic [vtag_width_p-1:0] itlb_miss_vtag_i,
      output logic                    itlb_miss_yumi_o,
      input  logic                    dtlb_miss_v_i,
      input  logic [vtag_width_p-1:0] dtlb_miss_vtag_i,
      output logic                    dtlb_miss_yumi_o,

      output logic                    ptw_v_o,
      output logic [vtag_width_p-1:0] ptw_vtag_o,
      input  logic                    ptw_ready_i,
      input  logic                    ptw_v_i,
      input  logic [vtag_width_p-1:0] ptw_vtag_i,
      input  logic [ptag_width_p-1:0] ptw_ptag_i,

      output logic                    itlb_w_v_o,
      output logic                    dtlb_w_v_o,
      output logic [vtag_width_p-1:0] w_vtag_o,
      output logic [ptag_width_p-1:0] w_ptag_o,

      output logic                    busy_o,
      output logic                    fault_v_o,
      output logic                    fault_dtlb_o
   );

   bp_be_tlb_miss_state_e   state_q, state_d;
   bp_be_tlb_miss_src_e     last_grant_q, last_grant_d;
   bp_be_tlb_miss_src_e     owner_q, owner_d;
   bp_be_tlb_miss_src_e     grant_id;
   logic [1:0]              grant;
   logic [vtag_width_p-1:0] vtag_q, vtag_d;
   logic [vtag_width_p-1:0] w_vtag_q, w_vtag_d;
   logic [ptag_width_p-1:0] w_ptag_q, w_ptag_d;
   logic                    resp_match;
   logic                    timeout;

   bp_be_tlb_miss_rr_arb rr_arb
      (.v_i          ({dtlb_miss_v_i, itlb_miss_v_i})
      ,.last_grant_i (last_grant_q)
      ,.en_i         ((state_q == e_state_idle) && !reset)
      ,.grant_o      (grant)
      ,.grant_id_o   (grant_id)
      );

   assign resp_match = ptw_v_i && (ptw_vtag_i == vtag_q);

`ifdef BP_BE_TLB_MISS_TIMEOUT_EN
   localparam int cnt_width_lp = `BSG_SAFE_CLOG2(timeout_cycles_p);

   logic [cnt_width_lp-1:0] cnt_q, cnt_d;

   // Held at zero outside WAIT so it starts from zero on every WAIT entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == e_state_wait) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout      = (state_q == e_state_wait) && !resp_match
                         && (cnt_q == cnt_width_lp'(timeout_cycles_p - 1));
   assign fault_v_o    = timeout && !reset;
   assign fault_dtlb_o = timeout && !reset && (owner_q == e_src_dtlb);
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (timeout_cycles_p >= 2);
   assign timeout            = 1'b0;
   assign fault_v_o          = 1'b0;
   assign fault_dtlb_o       = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      vtag_d       = vtag_q;
      w_vtag_d     = w_vtag_q;
      w_ptag_d     = w_ptag_q;
      case (state_q)
         e_state_idle: begin
            if (grant != 2'b00) begin
               owner_d      = grant_id;
               last_grant_d = grant_id;
               vtag_d       = (grant_id == e_src_dtlb) ? dtlb_miss_vtag_i : itlb_miss_vtag_i;
               state_d      = e_state_req;
            end
         end
         e_state_req: begin
            if (ptw_ready_i) begin
               state_d = e_state_wait;
            end
         end
         e_state_wait: begin
            // A matching response on the timeout cycle still fills.
            if (resp_match) begin
               w_vtag_d = vtag_q;
               w_ptag_d = ptw_ptag_i;
               state_d  = e_state_fill;
            end else if (timeout) begin
               state_d  = e_state_idle;
            end
         end
         e_state_fill: begin
            state_d = e_state_idle;
         end
         default: begin
            state_d = e_state_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= e_state_idle;
         last_grant_q <= e_src_dtlb;
         owner_q      <= e_src_itlb;
         vtag_q       <= '0;
         w_vtag_q     <= '0;
         w_ptag_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         vtag_q       <= vtag_d;
         w_vtag_q     <= w_vtag_d;
         w_ptag_q     <= w_ptag_d;
      end
   end

   assign itlb_miss_yumi_o = grant[0];
   assign dtlb_miss_yumi_o = grant[1];
   assign ptw_v_o          = !reset && (state_q == e_state_req);
   assign ptw_vtag_o       = vtag_q;
   assign itlb_w_v_o       = !reset && (state_q == e_state_fill) && (owner_q == e_src_itlb);
   assign dtlb_w_v_o       = !reset && (state_q == e_state_fill) && (owner_q == e_src_dtlb);
   assign w_vtag_o         = w_vtag_q;
   assign w_ptag_o         = w_ptag_q;
   assign busy_o           = !reset && (state_q != e_state_idle);

endmodule

// File: tb/tb_bp_be_tlb_miss_arbiter.sv
// Bench for bp_be_tlb_miss_arbiter: directed scenarios plus a randomized phase, scoreboarded
// against a transaction-level model (one outstanding walk, round-robin winner, fill due cycle).
module tb_bp_be_tlb_miss_arbiter;

   localparam int VW = 27;
   localparam int PW = 28;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          itlb_miss_v_i, dtlb_miss_v_i;
   logic [VW-1:0] itlb_miss_vtag_i, dtlb_miss_vtag_i;
   logic          itlb_miss_yumi_o, dtlb_miss_yumi_o;
   logic          ptw_v_o, ptw_ready_i, ptw_v_i;
   logic [VW-1:0] ptw_vtag_o, ptw_vtag_i;
   logic [PW-1:0] ptw_ptag_i;
   logic          itlb_w_v_o, dtlb_w_v_o;
   logic [VW-1:0] w_vtag_o;
   logic [PW-1:0] w_ptag_o;
   logic          busy_o, fault_v_o, fault_dtlb_o;

   always #5 clk = ~clk;

   bp_be_tlb_miss_arbiter #(
      .vtag_width_p     (VW),
      .ptag_width_p     (PW),
      .timeout_cycles_p (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .itlb_miss_v_i    (itlb_miss_v_i),
      .itlb_miss_vtag_i (itlb_miss_vtag_i),
      .itlb_miss_yumi_o (itlb_miss_yumi_o),
      .dtlb_miss_v_i    (dtlb_miss_v_i),
      .dtlb_miss_vtag_i (dtlb_miss_vtag_i),
      .dtlb_miss_yumi_o (dtlb_miss_yumi_o),
      .ptw_v_o          (ptw_v_o),
      .ptw_vtag_o       (ptw_vtag_o),
      .ptw_ready_i      (ptw_ready_i),
      .ptw_v_i          (ptw_v_i),
      .ptw_vtag_i       (ptw_vtag_i),
      .ptw_ptag_i       (ptw_ptag_i),
      .itlb_w_v_o       (itlb_w_v_o),
      .dtlb_w_v_o       (dtlb_w_v_o),
      .w_vtag_o         (w_vtag_o),
      .w_ptag_o         (w_ptag_o),
      .busy_o           (busy_o),
      .fault_v_o        (fault_v_o),
      .fault_dtlb_o     (fault_dtlb_o)
   );

   typedef struct {
      bit            dtlb;
      logic [VW-1:0] vtag;
      logic [PW-1:0] ptag;
      int            due;
   } fill_t;

   fill_t         fill_q[$];
   bit            grant_log[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            last_fill_cyc = -1;
   int            fault_due = -1;
   bit            fault_own = 1'b0;
   // Model of the single walk in flight.
   bit            outstanding = 1'b0;
   bit            req_pending = 1'b0;
   bit            last_d = 1'b1;
   bit            cur_dtlb = 1'b0;
   logic [VW-1:0] cur_vtag = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_fill(input bit dtlb, input logic [VW-1:0] vtag,
                                     input logic [PW-1:0] ptag, input int due);
      fill_t f;
      f.dtlb = dtlb;
      f.vtag = vtag;
      f.ptag = ptag;
      f.due  = due;
      fill_q.push_back(f);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard: samples on the falling edge, away from the active edge.
   initial begin
      fill_t      e;
      logic [1:0] exp_y;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_yumi", {dtlb_miss_yumi_o, itlb_miss_yumi_o}, 2'b00);
            check("rst_ptw_v", ptw_v_o, 1'b0);
            check("rst_strobes", {dtlb_w_v_o, itlb_w_v_o}, 2'b00);
            check("rst_busy", busy_o, 1'b0);
            check("rst_fault", fault_v_o, 1'b0);
            outstanding = 1'b0;
            req_pending = 1'b0;
            last_d      = 1'b1;
            fault_due   = -1;
            fill_q.delete();
         end else begin
            check("busy", busy_o, outstanding);
            exp_y = 2'b00;
            if (!outstanding) begin
               if (itlb_miss_v_i && dtlb_miss_v_i) exp_y = last_d ? 2'b01 : 2'b10;
               else                                exp_y = {dtlb_miss_v_i, itlb_miss_v_i};
            end
            if (exp_y != 2'b00 || itlb_miss_yumi_o || dtlb_miss_yumi_o)
               check("yumi", {dtlb_miss_yumi_o, itlb_miss_yumi_o}, exp_y);
            if (itlb_miss_yumi_o || dtlb_miss_yumi_o) grant_log.push_back(dtlb_miss_yumi_o);

            check("ptw_v", ptw_v_o, req_pending);
            if (ptw_v_o && req_pending) check("ptw_vtag", ptw_vtag_o, cur_vtag);

            if (itlb_w_v_o || dtlb_w_v_o) begin
               if (fill_q.size() == 0) begin
                  check("fill_spurious", {dtlb_w_v_o, itlb_w_v_o}, 2'b00);
               end else begin
                  e = fill_q.pop_front();
                  check("fill_owner", {dtlb_w_v_o, itlb_w_v_o}, e.dtlb ? 2'b10 : 2'b01);
                  check("fill_vtag", w_vtag_o, e.vtag);
                  check("fill_ptag", w_ptag_o, e.ptag);
                  check("fill_cycle", cyc, e.due);
               end
               last_fill_cyc = cyc;
               outstanding   = 1'b0;
            end else if (fill_q.size() != 0 && fill_q[0].due <= cyc) begin
               check("fill_missing", {dtlb_w_v_o, itlb_w_v_o}, fill_q[0].dtlb ? 2'b10 : 2'b01);
               void'(fill_q.pop_front());
               outstanding = 1'b0;
            end

            check("fault_v", fault_v_o, (cyc == fault_due));
            if (cyc == fault_due) begin
               check("fault_dtlb", fault_dtlb_o, fault_own);
               outstanding = 1'b0;
               fault_due   = -1;
            end

            if (ptw_v_o && ptw_ready_i && req_pending) req_pending = 1'b0;
            if (exp_y != 2'b00) begin
               outstanding = 1'b1;
               req_pending = 1'b1;
               cur_dtlb    = exp_y[1];
               cur_vtag    = exp_y[1] ? dtlb_miss_vtag_i : itlb_miss_vtag_i;
               last_d      = exp_y[1];
            end
         end
      end
   end

   // Acts as the PTW for one walk: ready after rdy_wait stalled cycles, then resp_wait
   // idle WAIT cycles (the first one carrying a wrong-vtag response if bad), then the answer.
   task automatic serve(input int rdy_wait, input int resp_wait, input bit bad, input logic [PW-1:0] ptag);
      int stall = 0;
      int n     = 0;
      bit acc   = 1'b0;
      while (!acc && n < 100) begin
         ptw_ready_i = (stall >= rdy_wait);
         @(negedge clk);
         acc = ptw_v_o && ptw_ready_i;
         if (ptw_v_o && !ptw_ready_i) stall++;
         n++;
         tick();
      end
      ptw_ready_i = 1'b0;
      if (!acc) check("serve_accept", acc, 1'b1);
      check("req_stall_cycles", stall, rdy_wait);
      for (int i = 0; i < resp_wait; i++) begin
         ptw_v_i    = bad && (i == 0);
         ptw_vtag_i = cur_vtag ^ VW'(32'h89);
         ptw_ptag_i = ~ptag;
         tick();
      end
      ptw_v_i    = 1'b1;
      ptw_vtag_i = cur_vtag;
      ptw_ptag_i = ptag;
      push_fill(cur_dtlb, cur_vtag, ptag, cyc + 1);
      tick();
      ptw_v_i = 1'b0;
      tick();
   endtask

   initial begin
      int g0;
      reset            = 1'b1;
      itlb_miss_v_i    = 1'b0;
      dtlb_miss_v_i    = 1'b0;
      itlb_miss_vtag_i = '0;
      dtlb_miss_vtag_i = '0;
      ptw_ready_i      = 1'b0;
      ptw_v_i          = 1'b0;
      ptw_vtag_i       = '0;
      ptw_ptag_i       = '0;
      repeat (3) tick();
      check("rst_w_vtag", w_vtag_o, '0);
      check("rst_w_ptag", w_ptag_o, '0);
      reset = 1'b0;
      tick();

      // Single ITLB miss, PTW ready at once, answer three cycles after the request.
      itlb_miss_v_i    = 1'b1;
      itlb_miss_vtag_i = VW'(32'h1234);
      ptw_ready_i      = 1'b1;
      g0 = cyc;
      tick();
      itlb_miss_v_i = 1'b0;
      serve(0, 2, 1'b0, PW'(32'hABCD));
      check("t1_grant_to_fill", last_fill_cyc - g0, 5);

      // Both misses held continuously from reset: I, D, I.
      reset = 1'b1;
      itlb_miss_v_i    = 1'b1;
      itlb_miss_vtag_i = VW'(32'h10);
      dtlb_miss_v_i    = 1'b1;
      dtlb_miss_vtag_i = VW'(32'h20);
      tick();
      reset = 1'b0;
      grant_log.delete();
      for (int k = 0; k < 3; k++) serve(0, 1, 1'b0, PW'($urandom));
      itlb_miss_v_i = 1'b0;
      dtlb_miss_v_i = 1'b0;
      check("t2_grant_count", grant_log.size(), 3);
      if (grant_log.size() >= 3) begin
         check("t2_grant0", grant_log[0], 1'b0);
         check("t2_grant1", grant_log[1], 1'b1);
         check("t2_grant2", grant_log[2], 1'b0);
      end
      tick();

      // PTW not ready for four cycles.
      itlb_miss_v_i    = 1'b1;
      itlb_miss_vtag_i = VW'(32'h55);
      tick();
      itlb_miss_v_i = 1'b0;
      serve(4, 1, 1'b0, PW'($urandom));

      // Wrong-vtag response before the right one.
      itlb_miss_v_i    = 1'b1;
      itlb_miss_vtag_i = VW'(32'h10);
      tick();
      itlb_miss_v_i = 1'b0;
      serve(0, 2, 1'b1, PW'($urandom));

      // Reset in WAIT, then a stale response.
      itlb_miss_v_i    = 1'b1;
      itlb_miss_vtag_i = VW'(32'h77);
      tick();
      itlb_miss_v_i = 1'b0;
      ptw_ready_i   = 1'b1;
      tick();
      ptw_ready_i = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      ptw_v_i    = 1'b1;
      ptw_vtag_i = VW'(32'h77);
      ptw_ptag_i = PW'($urandom);
      tick();
      ptw_v_i = 1'b0;
      repeat (2) tick();
      check("t5_busy_after_reset", busy_o, 1'b0);
      dtlb_miss_v_i    = 1'b1;
      dtlb_miss_vtag_i = VW'(32'h3);
      tick();
      dtlb_miss_v_i = 1'b0;
      serve(1, 3, 1'b0, PW'($urandom));

`ifdef BP_BE_TLB_MISS_TIMEOUT_EN
      // No response: fault TO cycles after the accepting REQ cycle; a late answer is dropped.
      dtlb_miss_v_i    = 1'b1;
      dtlb_miss_vtag_i = VW'(32'h4D);
      tick();
      dtlb_miss_v_i = 1'b0;
      ptw_ready_i   = 1'b1;
      fault_due     = cyc + TO;
      fault_own     = 1'b1;
      tick();
      ptw_ready_i = 1'b0;
      repeat (TO) tick();
      ptw_v_i    = 1'b1;
      ptw_vtag_i = VW'(32'h4D);
      tick();
      ptw_v_i = 1'b0;
      repeat (2) tick();
`endif

      // Randomized traffic with a free-running PTW responder.
      begin
         int ph   = 0;
         int wcnt = 0;
         bit iy   = 1'b0;
         bit dy   = 1'b0;
         for (int c = 0; c < 1500; c++) begin
            if (c >= 1400) begin
               itlb_miss_v_i = 1'b0;
               dtlb_miss_v_i = 1'b0;
            end else begin
               if (iy) begin
                  itlb_miss_v_i    = $urandom_range(1, 0) == 1;
                  itlb_miss_vtag_i = VW'($urandom);
               end else if (itlb_miss_v_i) begin
                  if ($urandom_range(15, 0) == 0) itlb_miss_v_i = 1'b0;
               end else if ($urandom_range(2, 0) == 0) begin
                  itlb_miss_v_i    = 1'b1;
                  itlb_miss_vtag_i = VW'($urandom);
               end
               if (dy) begin
                  dtlb_miss_v_i    = $urandom_range(1, 0) == 1;
                  dtlb_miss_vtag_i = VW'($urandom_range(63, 0));
               end else if (dtlb_miss_v_i) begin
                  if ($urandom_range(15, 0) == 0) dtlb_miss_v_i = 1'b0;
               end else if ($urandom_range(2, 0) == 0) begin
                  dtlb_miss_v_i    = 1'b1;
                  dtlb_miss_vtag_i = VW'($urandom_range(63, 0));
               end
            end
            ptw_ready_i = $urandom_range(2, 0) != 0;
            ptw_v_i     = 1'b0;
            ptw_vtag_i  = VW'($urandom);
            ptw_ptag_i  = PW'($urandom);
            if (ph == 1) begin
               if (wcnt == 0) begin
                  ptw_v_i    = 1'b1;
                  ptw_vtag_i = cur_vtag;
                  push_fill(cur_dtlb, cur_vtag, ptw_ptag_i, cyc + 1);
                  ph = 2;
               end else begin
                  wcnt--;
                  if ($urandom_range(3, 0) == 0) begin
                     ptw_v_i    = 1'b1;
                     ptw_vtag_i = cur_vtag ^ VW'($urandom_range(7, 1));
                  end
               end
            end else if (ph == 2) begin
               ph = 0;
            end else if ($urandom_range(7, 0) == 0) begin
               ptw_v_i    = 1'b1;
               ptw_vtag_i = cur_vtag;
            end
            @(negedge clk);
            iy = itlb_miss_yumi_o;
            dy = dtlb_miss_yumi_o;
            if (ptw_v_o && ptw_ready_i && ph == 0) begin
               ph   = 1;
               wcnt = $urandom_range(5, 0);
            end
            tick();
         end
         ptw_v_i     = 1'b0;
         ptw_ready_i = 1'b0;
      end
      repeat (2) tick();
      check("drain_fills_left", fill_q.size(), 0);
      check("drain_busy", busy_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
